// File: rtl/calc_entry_fsm.sv
// Calculator key-entry controller: builds two BCD operands and an operator
// from decoded key events, hands them to the ALU with a start/done
// handshake, and keeps the result on the display.
module calc_entry_fsm #(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    btn_press,
   input  logic                    is_num,
   input  logic                    is_op,
   input  logic                    is_eq,
   input  logic [3:0]              num_val,
   input  logic [1:0]              op_val,
   input  logic                    exec_done,
   input  logic [4*NUM_DIGITS-1:0] result_bcd,
   input  logic                    result_err,
   output logic [4*NUM_DIGITS-1:0] operand_a,
   output logic [4*NUM_DIGITS-1:0] operand_b,
   output logic [1:0]              op_code,
   output logic                    exec_start,
   output logic [4*NUM_DIGITS-1:0] display_bcd,
   output logic                    err,
   output logic [1:0]              state
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      S_A      = 2'd0,
      S_B      = 2'd1,
      S_EXEC   = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            press_q, press_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [CW-1:0]   a_cnt_q, a_cnt_d;
   logic [CW-1:0]   b_cnt_q, b_cnt_d;
   logic [1:0]      op_code_q, op_code_d;
   logic            exec_start_q, exec_start_d;
   logic            err_q, err_d;

   logic            key_evt;
   logic            evt_eq;
   logic            evt_op;
   logic            evt_num;

   // A digit is taken unless the operand is full or it would be a leading zero.
   function automatic logic digit_ok(input logic [CW-1:0] cnt, input logic [3:0] d);
      return (cnt != CNT_MAX) && !((cnt == '0) && (d == 4'd0));
   endfunction

   function automatic logic [W-1:0] shift_in(input logic [W-1:0] x, input logic [3:0] d);
      return {x[W-5:0], d};
   endfunction

   // Rising edge of btn_press is the single event for a held key; class
   // priority is equals, then operator, then digit. Non-decimal digits drop.
   always_comb begin
      key_evt = btn_press & ~press_q;
      evt_eq  = key_evt & is_eq;
      evt_op  = key_evt & ~is_eq & is_op;
      evt_num = key_evt & ~is_eq & ~is_op & is_num & (num_val <= 4'd9);
   end

   // Next-state and datapath updates for the entry sequence.
   always_comb begin
      state_d      = state_q;
      press_d      = btn_press;
      a_d          = a_q;
      b_d          = b_q;
      a_cnt_d      = a_cnt_q;
      b_cnt_d      = b_cnt_q;
      op_code_d    = op_code_q;
      exec_start_d = 1'b0;
      err_d        = err_q;

      case (state_q)
         S_A: begin
            if (evt_num) begin
               if (digit_ok(a_cnt_q, num_val)) begin
                  a_d     = shift_in(a_q, num_val);
                  a_cnt_d = a_cnt_q + CNT_ONE;
               end
            end else if (evt_op && (op_val != 2'd0)) begin
               op_code_d = op_val;
               b_d       = '0;
               b_cnt_d   = '0;
               state_d   = S_B;
            end
         end
         S_B: begin
            if (evt_eq) begin
               exec_start_d = 1'b1;
               state_d      = S_EXEC;
            end else if (evt_op) begin
               // Operator replacement only while B is still empty.
               if ((b_cnt_q == '0) && (op_val != 2'd0)) begin
                  op_code_d = op_val;
               end
            end else if (evt_num) begin
               if (digit_ok(b_cnt_q, num_val)) begin
                  b_d     = shift_in(b_q, num_val);
                  b_cnt_d = b_cnt_q + CNT_ONE;
               end
            end
         end
         S_EXEC: begin
            // Operands stay frozen and keys are dropped until the ALU answers.
            if (exec_done) begin
               a_d     = result_bcd;
               a_cnt_d = CNT_MAX;
               err_d   = result_err;
               state_d = S_RESULT;
            end
         end
         S_RESULT: begin
            if (evt_num) begin
               // A new digit starts a fresh calculation with that digit in A.
               err_d   = 1'b0;
               a_d     = {{(W-4){1'b0}}, num_val};
               a_cnt_d = (num_val == 4'd0) ? '0 : CNT_ONE;
               state_d = S_A;
            end else if (evt_op && !err_q && (op_val != 2'd0)) begin
               // Chain: the result stays in A as the next left operand.
               op_code_d = op_val;
               b_d       = '0;
               b_cnt_d   = '0;
               state_d   = S_B;
            end
         end
         default: state_d = S_A;
      endcase
   end

   // State and operand registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_A;
         press_q      <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         a_cnt_q      <= '0;
         b_cnt_q      <= '0;
         op_code_q    <= 2'd0;
         exec_start_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         press_q      <= press_d;
         a_q          <= a_d;
         b_q          <= b_d;
         a_cnt_q      <= a_cnt_d;
         b_cnt_q      <= b_cnt_d;
         op_code_q    <= op_code_d;
         exec_start_q <= exec_start_d;
         err_q        <= err_d;
      end
   end

   // Show B once the user has typed into it, otherwise A (or the result).
   always_comb begin
      display_bcd = ((state_q == S_B) && (b_cnt_q != '0)) ? b_q : a_q;
   end

   assign operand_a  = a_q;
   assign operand_b  = b_q;
   assign op_code    = op_code_q;
   assign exec_start = exec_start_q;
   assign err        = err_q;
   assign state      = state_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed scenarios plus random key sequences
// against a decimal-arithmetic model of the calculator; ALU requests are
// scoreboarded and answered by a responder process.
module tb_calc_entry_fsm;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk;
   logic         rst;
   logic         btn_press, is_num, is_op, is_eq;
   logic [3:0]   num_val;
   logic [1:0]   op_val;
   logic         exec_done, result_err;
   logic [W-1:0] result_bcd;
   logic [W-1:0] operand_a, operand_b, display_bcd;
   logic [1:0]   op_code, state;
   logic         exec_start, err;

   logic         done_alu, done_stray, alu_err;
   logic [W-1:0] alu_bcd, stray_bcd;

   assign exec_done  = done_alu | done_stray;
   assign result_bcd = done_stray ? stray_bcd : alu_bcd;
   assign result_err = done_stray ? 1'b1 : alu_err;

   calc_entry_fsm #(.NUM_DIGITS(N)) dut (
      .clk(clk), .rst(rst), .btn_press(btn_press), .is_num(is_num),
      .is_op(is_op), .is_eq(is_eq), .num_val(num_val), .op_val(op_val),
      .exec_done(exec_done), .result_bcd(result_bcd), .result_err(result_err),
      .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
      .exec_start(exec_start), .display_bcd(display_bcd), .err(err),
      .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: operands as plain decimal integers with digit counts.
   int  m_a, m_acnt, m_b, m_bcnt, m_op, m_phase;  // phase 0=A 1=B 2=exec 3=result
   bit  m_err;
   bit  busy;
   int  alu_delay;
   int  n_chk, n_fail;

   typedef struct {int a; int b; int op;} job_t;
   job_t exp_q[$];

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < N; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int disp;
      disp = (m_phase == 1 && m_bcnt > 0) ? m_b : m_a;
      chk({tag, "_state"},      32'(state),       32'(m_phase));
      chk({tag, "_operand_a"},  32'(operand_a),   32'(to_bcd(m_a)));
      chk({tag, "_operand_b"},  32'(operand_b),   32'(to_bcd(m_b)));
      chk({tag, "_op_code"},    32'(op_code),     32'(m_op));
      chk({tag, "_err"},        32'(err),         32'(m_err));
      chk({tag, "_display"},    32'(display_bcd), 32'(to_bcd(disp)));
      chk({tag, "_exec_start"}, 32'(exec_start),  32'd0);
   endtask

   task automatic model_reset();
      m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0; m_op = 0; m_phase = 0; m_err = 0;
   endtask

   // Decimal digit entry: full operand or leading zero leaves it unchanged.
   task automatic enter(inout int v, inout int c, input int d);
      if (c == N) return;
      if (c == 0 && d == 0) return;
      v = v * 10 + d;
      c = c + 1;
   endtask

   task automatic model_key(input bit e, input bit o, input bit n, input int nv, input int ov);
      if (m_phase == 2) return;
      if (e) begin
         if (m_phase == 1) begin
            exp_q.push_back('{a: m_a, b: m_b, op: m_op});
            busy    = 1;
            m_phase = 2;
         end
      end else if (o) begin
         if (ov == 0) return;
         if (m_phase == 0 || (m_phase == 3 && !m_err)) begin
            m_op = ov; m_b = 0; m_bcnt = 0; m_phase = 1;
         end else if (m_phase == 1 && m_bcnt == 0) begin
            m_op = ov;
         end
      end else if (n) begin
         if (nv > 9) return;
         case (m_phase)
            0: enter(m_a, m_acnt, nv);
            1: enter(m_b, m_bcnt, nv);
            3: begin
               m_err = 0; m_a = 0; m_acnt = 0;
               enter(m_a, m_acnt, nv);
               m_phase = 0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic press(input bit e, input bit o, input bit n, input int nv, input int ov,
                        input int hold);
      @(negedge clk);
      btn_press = 1'b1; is_eq = e; is_op = o; is_num = n;
      num_val = 4'(nv); op_val = 2'(ov);
      model_key(e, o, n, nv, ov);
      repeat (hold - 1) @(negedge clk);
      @(negedge clk);
      btn_press = 1'b0; is_eq = 1'b0; is_op = 1'b0; is_num = 1'b0;
      num_val = 4'd0; op_val = 2'd0;
      @(negedge clk);
      #1 check_all("key");
   endtask

   task automatic digit(input int d);
      press(0, 0, 1, d, 0, 1);
   endtask

   task automatic oper(input int ov);
      press(0, 1, 0, 0, ov, 1);
   endtask

   task automatic equals();
      press(1, 0, 0, 0, 0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && busy; i++) @(negedge clk);
      chk("exec_timeout", 32'(busy), 32'd0);
      busy = 0;
      @(negedge clk);
      #1 check_all("idle");
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1 check_all("reset");
   endtask

   task automatic stray_done();
      @(negedge clk);
      done_stray = 1'b1;
      stray_bcd  = W'($urandom);
      @(negedge clk);
      done_stray = 1'b0;
      @(negedge clk);
      #1 check_all("stray_done");
   endtask

   // Monitor and ALU responder: each exec_start must match a queued request;
   // it is answered with the decimal result after alu_delay cycles.
   initial begin
      job_t job;
      int   rv;
      bit   re;
      done_alu = 1'b0; alu_bcd = '0; alu_err = 1'b0;
      forever begin
         @(negedge clk);
         if (exec_start === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL exec_start_unexpected: got pulse, expected none (t=%0t)", $time);
            end else begin
               job = exp_q.pop_front();
               chk("exec_operand_a", 32'(operand_a), 32'(to_bcd(job.a)));
               chk("exec_operand_b", 32'(operand_b), 32'(to_bcd(job.b)));
               chk("exec_op_code",   32'(op_code),   32'(job.op));
               case (job.op)
                  1:       rv = job.a + job.b;
                  2:       rv = job.a - job.b;
                  default: rv = job.a * job.b;
               endcase
               re = (rv < 0) || (rv > 9999);
               if (rv < 0) rv = 0;
               else rv = rv % 10000;
               repeat (alu_delay) @(negedge clk);
               done_alu = 1'b1; alu_bcd = to_bcd(rv); alu_err = re;
               @(negedge clk);
               done_alu = 1'b0;
               if (m_phase == 2) begin
                  m_a = rv; m_acnt = N; m_err = re; m_phase = 3;
               end
               busy = 0;
            end
         end
      end
   end

   initial begin
      int  r, nv, ov, hold;
      bit  e, o, n;
      n_chk = 0; n_fail = 0; busy = 0; alu_delay = 2;
      rst = 1'b1; btn_press = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
      num_val = 4'd0; op_val = 2'd0; done_stray = 1'b0; stray_bcd = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 check_all("por");

      // 12 + 3 = 15
      digit(1); digit(2); oper(1); digit(3);
      alu_delay = 3;
      equals();
      wait_idle();
      chk("t1_display", 32'(display_bcd), 32'h0015);
      chk("t1_state",   32'(state),       32'd3);

      // leading zeros dropped, fifth significant digit rejected
      do_reset();
      digit(0); digit(0); digit(7);
      chk("t2_a_7", 32'(operand_a), 32'h0007);
      digit(1); digit(2); digit(3); digit(4);
      chk("t2_a_7123", 32'(display_bcd), 32'h7123);

      // held key gives one digit
      do_reset();
      press(0, 0, 1, 5, 0, 20);
      chk("t3_a_5", 32'(operand_a), 32'h0005);

      // operator replacement, then ignored once B has digits
      do_reset();
      digit(9); oper(1); oper(2); digit(4);
      chk("t4_op", 32'(op_code), 32'd2);
      oper(3);
      chk("t4_op_kept", 32'(op_code), 32'd2);
      alu_delay = 1;
      equals();
      wait_idle();

      // keys dropped during exec, error result blocks chaining
      do_reset();
      digit(5); oper(2); digit(7);
      alu_delay = 10;
      equals();
      digit(8);
      wait_idle();
      chk("t5_err", 32'(err), 32'd1);
      oper(1);
      chk("t5_state_result", 32'(state), 32'd3);
      digit(3);
      chk("t5_a_3", 32'(operand_a), 32'h0003);
      chk("t5_err_clr", 32'(err), 32'd0);

      // same-cycle done, chaining, then reset in the middle of exec
      do_reset();
      digit(7); oper(1); digit(8);
      alu_delay = 0;
      equals();
      wait_idle();
      oper(2); digit(2);
      alu_delay = 15;
      equals();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1 check_all("mid_exec_reset");
      wait_idle();
      chk("t6_state_a", 32'(state), 32'd0);

      // empty B and stray done outside exec
      digit(4); oper(3);
      stray_done();
      alu_delay = 2;
      equals();
      wait_idle();
      stray_done();

      // random key streams
      for (int k = 0; k < 300; k++) begin
         r    = $urandom_range(0, 99);
         nv   = $urandom_range(0, 9);
         ov   = $urandom_range(1, 3);
         hold = $urandom_range(1, 4);
         e = 0; o = 0; n = 0;
         if (r < 55) n = 1;
         else if (r < 75) o = 1;
         else if (r < 87) e = 1;
         else if (r < 93) begin e = 1'($urandom_range(0, 1)); o = 1; n = 1; end
         if (n && !o && !e && (m_phase == 0 || m_phase == 1) && $urandom_range(0, 9) == 0)
            nv = $urandom_range(10, 15);
         alu_delay = $urandom_range(0, 5);
         if (r >= 97) stray_done();
         else press(e, o, n, nv, ov, hold);
         if (busy) wait_idle();
      end

      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
